// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// alignment legality check used at request acceptance.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [SIZE_W-1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } acc_size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // Size code 3 is never legal; halves need an even address, words a 4-byte one.
  function automatic logic is_bad_access(input logic [SIZE_W-1:0] size,
                                         input logic [1:0]        addr_lo);
    logic bad;
    bad = 1'b1;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/half of a
// read word, and merges store data into a read word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic [SIZE_W-1:0] i_size,
  input  logic              i_unsigned,
  input  logic [WORD_W-1:0] i_rdata,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_load_data_c,
  output logic [WORD_W-1:0] o_merge_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Load path: select lane, then sign- or zero-extend.
  always_comb begin
    w_byte        = 8'h00;
    w_half        = 16'h0000;
    w_sign        = 1'b0;
    o_load_data_c = i_rdata;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      BYTE: begin
        w_sign        = ~i_unsigned & w_byte[7];
        o_load_data_c = {{24{w_sign}}, w_byte};
      end
      HALF: begin
        w_sign        = ~i_unsigned & w_half[15];
        o_load_data_c = {{16{w_sign}}, w_half};
      end
      default: o_load_data_c = i_rdata;
    endcase
  end

  // Store path: only the addressed lanes take the low bits of the store data.
  always_comb begin
    o_merge_data_c = i_wdata;
    case (i_size)
      BYTE: begin
        o_merge_data_c = i_rdata;
        case (i_addr_lo)
          2'd0:    o_merge_data_c[7:0]   = i_wdata[7:0];
          2'd1:    o_merge_data_c[15:8]  = i_wdata[7:0];
          2'd2:    o_merge_data_c[23:16] = i_wdata[7:0];
          default: o_merge_data_c[31:24] = i_wdata[7:0];
        endcase
      end
      HALF: begin
        o_merge_data_c = i_rdata;
        if (i_addr_lo[1]) o_merge_data_c[31:16] = i_wdata[15:0];
        else              o_merge_data_c[15:0]  = i_wdata[15:0];
      end
      default: o_merge_data_c = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a core request port to a
// word-wide memory; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [DATA_SIZE-1:0] resp_rdata,
  output logic                 resp_error,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_write_enable,
  output logic [DATA_SIZE-1:0] mem_write_data,
  input  logic [DATA_SIZE-1:0] mem_read_data,
  output logic                 mem_valid,
  input  logic                 mem_ready
);

  if (DATA_SIZE != 32) begin : g_bad_data_size
    $error("load_store_unit: only DATA_SIZE=32 is supported");
  end

  lsu_state_e           r_state,       w_state_nxt;
  logic [1:0]           r_addr_lo,     w_addr_lo_nxt;
  logic [SIZE_W-1:0]    r_size,        w_size_nxt;
  logic                 r_unsigned,    w_unsigned_nxt;
  logic [DATA_SIZE-1:0] r_wdata,       w_wdata_nxt;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [DATA_SIZE-1:0] r_resp_rdata,  w_resp_rdata_nxt;
  logic                 r_resp_error,  w_resp_error_nxt;
  logic [ADDR_SIZE-1:0] r_mem_addr,    w_mem_addr_nxt;
  logic                 r_mem_valid,   w_mem_valid_nxt;
  logic                 r_mem_we,      w_mem_we_nxt;
  logic [DATA_SIZE-1:0] r_mem_wdata,   w_mem_wdata_nxt;
  logic [WORD_W-1:0]    w_load_data_c;
  logic [WORD_W-1:0]    w_merge_data_c;

  lsu_lane_align u_lane_align (
    .i_addr_lo      (r_addr_lo),
    .i_size         (r_size),
    .i_unsigned     (r_unsigned),
    .i_rdata        (WORD_W'(mem_read_data)),
    .i_wdata        (WORD_W'(r_wdata)),
    .o_load_data_c  (w_load_data_c),
    .o_merge_data_c (w_merge_data_c)
  );

  // Next-state and next-output logic; memory outputs hold unless a transition changes them.
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_lo_nxt    = r_addr_lo;
    w_size_nxt       = r_size;
    w_unsigned_nxt   = r_unsigned;
    w_wdata_nxt      = r_wdata;
    w_resp_rdata_nxt = '0;
    w_resp_error_nxt = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_valid_nxt  = r_mem_valid;
    w_mem_we_nxt     = r_mem_we;
    w_mem_wdata_nxt  = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_addr_lo_nxt  = req_addr[1:0];
          w_size_nxt     = req_size;
          w_unsigned_nxt = req_unsigned;
          w_wdata_nxt    = req_wdata;
          if (is_bad_access(req_size, req_addr[1:0])) begin
            w_state_nxt      = RESP;
            w_resp_error_nxt = 1'b1;
          end else begin
            w_mem_addr_nxt  = {req_addr[ADDR_SIZE-1:2], 2'b00};
            w_mem_valid_nxt = 1'b1;
            if (!req_write) begin
              w_state_nxt = LOAD;
            end else if (req_size == WORD) begin
              w_state_nxt     = STORE;
              w_mem_we_nxt    = 1'b1;
              w_mem_wdata_nxt = req_wdata;
            end else begin
              w_state_nxt = RMW_RD;
            end
          end
        end
      end
      LOAD: begin
        if (mem_ready) begin
          w_state_nxt      = RESP;
          w_resp_rdata_nxt = DATA_SIZE'(w_load_data_c);
          w_mem_addr_nxt   = '0;
          w_mem_valid_nxt  = 1'b0;
          w_mem_we_nxt     = 1'b0;
          w_mem_wdata_nxt  = '0;
        end
      end
      RMW_RD: begin
        if (mem_ready) begin
          w_state_nxt     = RMW_WR;
          w_mem_we_nxt    = 1'b1;
          w_mem_wdata_nxt = DATA_SIZE'(w_merge_data_c);
        end
      end
      STORE, RMW_WR: begin
        if (mem_ready) begin
          w_state_nxt     = RESP;
          w_mem_addr_nxt  = '0;
          w_mem_valid_nxt = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_wdata_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_mem_addr_nxt  = '0;
        w_mem_valid_nxt = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_wdata_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_addr_lo    <= 2'b00;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr_lo    <= w_addr_lo_nxt;
      r_size       <= w_size_nxt;
      r_unsigned   <= w_unsigned_nxt;
      r_wdata      <= w_wdata_nxt;
      r_req_ready  <= (w_state_nxt == IDLE);
      r_resp_valid <= (w_state_nxt == RESP);
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_error <= w_resp_error_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_rdata       = r_resp_rdata;
  assign resp_error       = r_resp_error;
  assign mem_addr         = r_mem_addr;
  assign mem_valid        = r_mem_valid;
  assign mem_write_enable = r_mem_we;
  assign mem_write_data   = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single requests against
// a word memory model, plus stall and mid-transaction reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_valid;
  logic        mem_ready = 1'b1;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready)
  );

  // Word memory model with a preload port and bus-protocol monitors.
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'h0;
  int unsigned n_writes = 0;
  int unsigned n_mem_cycles = 0;
  int unsigned n_prot = 0;

  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    if (mem_valid && mem_write_enable && mem_ready) begin
      mem[mem_addr[7:2]] <= mem_write_data;
      n_writes <= n_writes + 1;
    end
    if (mem_valid) n_mem_cycles <= n_mem_cycles + 1;
    if (rst && mem_write_enable && !mem_valid) n_prot <= n_prot + 1;
    if (rst && mem_valid && (mem_addr[1:0] != 2'b00)) n_prot <= n_prot + 1;
    if (rst && !mem_valid && ((mem_addr != 32'h0) || (mem_write_data != 32'h0)))
      n_prot <= n_prot + 1;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_idx  = addr[7:2];
    pre_data = data;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  // Issues one request from a negedge, measures latency in cycles after acceptance.
  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int unsigned w0;
    int unsigned m0;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    preload(v.addr, v.init);
    w0 = n_writes;
    m0 = n_mem_cycles;
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, " error"}, 32'(resp_error), 32'(v.exp_err));
    @(negedge clk);
    chk({tag, " resp_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, " mem_word"}, mem[v.addr[7:2]], v.exp_word);
    chk({tag, " writes"}, n_writes - w0, (v.wr && !v.exp_err) ? 32'd1 : 32'd0);
    chk({tag, " mem_used"}, 32'(n_mem_cycles != m0), 32'(!v.exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned w0;
    int          resp_seen;
    vec_t        v;

    //           wr    size   uns   addr         wdata         init          exp_rdata     err  lat exp_word
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h43, 32'h0,        32'hA1B2C3D4, 32'hFFFFFFA1, 1'b0, 2, 32'hA1B2C3D4};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h40, 32'h0,        32'hA1B2C3D4, 32'h0000C3D4, 1'b0, 2, 32'hA1B2C3D4};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h42, 32'h0,        32'hA1B2C3D4, 32'hFFFFA1B2, 1'b0, 2, 32'hA1B2C3D4};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h41, 32'h0,        32'hA1B2C3D4, 32'h000000C3, 1'b0, 2, 32'hA1B2C3D4};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'hA1B2C3D4, 32'hA1B2C3D4, 1'b0, 2, 32'hA1B2C3D4};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h50, 32'h0,        32'h8000007F, 32'h0000007F, 1'b0, 2, 32'h8000007F};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 32'h41, 32'h00000055, 32'hA1B2C3D4, 32'h00000000, 1'b0, 3, 32'hA1B255D4};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h46, 32'hDEADBEEF, 32'h11223344, 32'h00000000, 1'b0, 3, 32'hBEEF3344};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h4B, 32'h123456AB, 32'h00000000, 32'h00000000, 1'b0, 3, 32'hAB000000};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h48, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2, 32'h12345678};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h42, 32'h0,        32'hA1B2C3D4, 32'h00000000, 1'b1, 1, 32'hA1B2C3D4};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h41, 32'h0,        32'hA1B2C3D4, 32'h00000000, 1'b1, 1, 32'hA1B2C3D4};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        32'hA1B2C3D4, 32'h00000000, 1'b1, 1, 32'hA1B2C3D4};
    vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h43, 32'h0000FFFF, 32'h13579BDF, 32'h00000000, 1'b1, 1, 32'h13579BDF};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_error", 32'(resp_error), 32'd0);
    chk("rst mem_valid", 32'(mem_valid), 32'd0);
    chk("rst mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_write_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Word store stalled by mem_ready=0 for three cycles.
    preload(32'h60, 32'h0);
    w0 = n_writes;
    req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h60; req_wdata = 32'h12345678; req_valid = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stall%0d mem_valid", c), 32'(mem_valid), 32'd1);
      chk($sformatf("stall%0d mem_we", c), 32'(mem_write_enable), 32'd1);
      chk($sformatf("stall%0d mem_addr", c), mem_addr, 32'h60);
      chk($sformatf("stall%0d mem_wdata", c), mem_write_data, 32'h12345678);
      chk($sformatf("stall%0d resp_valid", c), 32'(resp_valid), 32'd0);
      if (c == 3) mem_ready = 1'b1;
      else        @(negedge clk);
    end
    @(negedge clk);
    chk("stall resp_valid", 32'(resp_valid), 32'd1);
    chk("stall writes", n_writes - w0, 32'd1);
    chk("stall mem_word", mem[24], 32'h12345678);
    @(negedge clk);

    // Reset asserted while the sub-word store sits in its write phase.
    preload(32'h70, 32'hA1B2C3D4);
    w0 = n_writes;
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h71; req_wdata = 32'h00000055; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_wr mem_we", 32'(mem_write_enable), 32'd1);
    chk("rmw_wr merged", mem_write_data, 32'hA1B255D4);
    mem_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst mem_valid", 32'(mem_valid), 32'd0);
    chk("midrst mem_we", 32'(mem_write_enable), 32'd0);
    chk("midrst mem_wdata", mem_write_data, 32'h0);
    rst = 1'b1;
    mem_ready = 1'b1;
    resp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    chk("midrst no_resp", 32'(resp_seen), 32'd0);
    chk("midrst no_write", n_writes - w0, 32'd0);
    chk("midrst mem_word", mem[28], 32'hA1B2C3D4);

    // Unit still works after the mid-transaction reset.
    v = '{1'b0, 2'd2, 1'b0, 32'h70, 32'h0, 32'hA1B2C3D4, 32'hA1B2C3D4, 1'b0, 2, 32'hA1B2C3D4};
    run_vec(v, 99);

    chk("bus protocol violations", n_prot, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
